dac_frame_scheduler: RTL and testbench

- Shares the DAC nibble serializer between up to NUM_CH sample sources.
- Arbitrates requesters round-robin and buffers granted samples in a small FIFO.
- Presents one DATA_W-bit word, held stable for exactly one DAC frame (FRAME_CLKS clk cycles), on the serializer's parallel data input.
- Generates the frame boundary strobe and handles underflow with a defined output code.

---
 rtl/dac_sched_pkg.sv | 38 +++
 rtl/dac_sched_fifo.sv | 49 ++++
 rtl/dac_frame_scheduler.sv | 110 +++++++++++
 tb/tb_dac_frame_scheduler.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/dac_sched_pkg.sv
// rtl/dac_sched_pkg.sv - shared types, defaults and round-robin pick for the DAC frame scheduler
package dac_sched_pkg;

  localparam int DATA_W_DEF = 14;
  localparam logic [DATA_W_DEF-1:0] IDLE_CODE_DEF = 14'h2000;
  localparam int MAX_CH = 8;
  localparam int CH_W_MAX = 3;

  typedef struct packed {
    logic [CH_W_MAX-1:0]   ch;
    logic [DATA_W_DEF-1:0] data;
  } sched_entry_t;

  typedef struct packed {
    logic                found;
    logic [CH_W_MAX-1:0] idx;
  } rr_pick_t;

  // Descending scan so the last hit written is the one closest after ptr.
  function automatic rr_pick_t rr_pick(input logic [MAX_CH-1:0] valid,
                                       input logic [CH_W_MAX-1:0] ptr,
                                       input int num_ch);
    rr_pick_t            res;
    logic [CH_W_MAX-1:0] c;
    res = '0;
    for (int k = MAX_CH - 1; k >= 0; k--) begin
      if (k < num_ch) begin
        c = CH_W_MAX'((int'(ptr) + k) % num_ch);
        if (valid[c]) begin
          res.found = 1'b1;
          res.idx   = c;
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/dac_sched_fifo.sv
// rtl/dac_sched_fifo.sv - single-clock sample FIFO with occupancy level
module dac_sched_fifo import dac_sched_pkg::*; #(
  parameter int WIDTH = CH_W_MAX + DATA_W_DEF,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      level_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      level_q <= level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/dac_frame_scheduler.sv
// rtl/dac_frame_scheduler.sv - round-robin sample arbiter feeding one DAC word per frame
module dac_frame_scheduler import dac_sched_pkg::*; #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = DATA_W_DEF,
  parameter int FRAME_CLKS = 8,
  parameter int FIFO_DEPTH = 4,
  parameter logic [DATA_W-1:0] IDLE_CODE = DATA_W'(IDLE_CODE_DEF),
  localparam int CH_W = $clog2(NUM_CH),
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1,
  localparam int TMR_W = $clog2(FRAME_CLKS)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     enable_i,
  input  logic                     hold_last_i,
  input  logic [NUM_CH-1:0]        req_valid_i,
  input  logic [NUM_CH*DATA_W-1:0] req_data_i,
  output logic [NUM_CH-1:0]        req_ready_o,
  output logic [DATA_W-1:0]        data_out_o,
  output logic [CH_W-1:0]          ch_out_o,
  output logic                     out_valid_o,
  output logic                     frame_start_o,
  output logic [LVL_W-1:0]         fifo_level_o,
  output logic [15:0]              underflow_cnt_o
);

  rr_pick_t                 pick;
  logic [CH_W-1:0]          ptr_q, ptr_d;
  logic [CH_W-1:0]          grant_idx;
  logic                     grant;
  logic [DATA_W-1:0]        data_sel;
  logic                     fifo_full, fifo_empty, pop;
  logic [CH_W+DATA_W-1:0]   fifo_wdata, fifo_rdata;
  logic [TMR_W-1:0]         timer_q;
  logic                     boundary;
  logic [DATA_W-1:0]        data_out_q;
  logic [CH_W-1:0]          ch_out_q;
  logic                     out_valid_q, frame_start_q;
  logic [15:0]              underflow_cnt_q;

  // Full is judged on the registered level, so a same-cycle pop never frees a slot for a grant.
  always_comb begin
    pick        = rr_pick(MAX_CH'(req_valid_i), CH_W_MAX'(ptr_q), NUM_CH);
    grant_idx   = CH_W'(pick.idx);
    grant       = pick.found && !fifo_full;
    req_ready_o = '0;
    data_sel    = '0;
    ptr_d       = ptr_q;
    if (grant) begin
      req_ready_o[grant_idx] = 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
        if (grant_idx == CH_W'(i)) data_sel = req_data_i[i*DATA_W +: DATA_W];
      end
      ptr_d = (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  assign fifo_wdata = {grant_idx, data_sel};
  assign boundary   = enable_i && (timer_q == TMR_W'(FRAME_CLKS - 1));
  assign pop        = boundary && !fifo_empty;

  dac_sched_fifo #(
    .WIDTH (CH_W + DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (grant),
    .wdata_i (fifo_wdata),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level_o)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ptr_q           <= '0;
      timer_q         <= '0;
      data_out_q      <= IDLE_CODE;
      ch_out_q        <= '0;
      out_valid_q     <= 1'b0;
      frame_start_q   <= 1'b0;
      underflow_cnt_q <= '0;
    end else begin
      ptr_q         <= ptr_d;
      frame_start_q <= boundary;
      if (!enable_i || boundary) timer_q <= '0;
      else                       timer_q <= timer_q + 1'b1;
      if (boundary) begin
        if (!fifo_empty) begin
          {ch_out_q, data_out_q} <= fifo_rdata;
          out_valid_q            <= 1'b1;
        end else begin
          out_valid_q <= 1'b0;
          if (!hold_last_i) data_out_q <= IDLE_CODE;
          if (underflow_cnt_q != 16'hFFFF) underflow_cnt_q <= underflow_cnt_q + 1'b1;
        end
      end
    end
  end

  assign data_out_o      = data_out_q;
  assign ch_out_o        = ch_out_q;
  assign out_valid_o     = out_valid_q;
  assign frame_start_o   = frame_start_q;
  assign underflow_cnt_o = underflow_cnt_q;

endmodule

// File: tb/tb_dac_frame_scheduler.sv
// tb/tb_dac_frame_scheduler.sv - directed self-checking bench for dac_frame_scheduler
module tb_dac_frame_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        hold_last;
  logic [3:0]  req_valid;
  logic [55:0] req_data;
  logic [3:0]  req_ready;
  logic [13:0] data_out;
  logic [1:0]  ch_out;
  logic        out_valid;
  logic        frame_start;
  logic [2:0]  fifo_level;
  logic [15:0] underflow_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [55:0] RR_DATA = {14'h0400, 14'h0300, 14'h0200, 14'h0100};

  dac_frame_scheduler dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .enable_i        (enable),
    .hold_last_i     (hold_last),
    .req_valid_i     (req_valid),
    .req_data_i      (req_data),
    .req_ready_o     (req_ready),
    .data_out_o      (data_out),
    .ch_out_o        (ch_out),
    .out_valid_o     (out_valid),
    .frame_start_o   (frame_start),
    .fifo_level_o    (fifo_level),
    .underflow_cnt_o (underflow_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in cycle 0: reset just released, enable high.
  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; hold_last = 1'b0; req_valid = '0; req_data = '0;
    tick(); tick();
    reset = 1'b0; enable = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (data_out !== 14'h2000) begin n_fail++; $display("FAIL rst_data got %h exp 2000", data_out); end
    n_checks++; if (ch_out !== 2'd0) begin n_fail++; $display("FAIL rst_ch got %0d exp 0", ch_out); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", out_valid); end
    n_checks++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL rst_fs got %b exp 0", frame_start); end
    n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL rst_level got %0d exp 0", fifo_level); end
    n_checks++; if (underflow_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_ucnt got %0d exp 0", underflow_cnt); end
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_ready got %b exp 0000", req_ready); end
  endtask

  task automatic test_idle_underflow();
    do_reset();
    for (int c = 1; c <= 24; c++) begin
      tick();
      n_checks++;
      if (frame_start !== ((c % 8) == 0)) begin
        n_fail++; $display("FAIL idle_fs cycle %0d got %b exp %b", c, frame_start, (c % 8) == 0);
      end
    end
    n_checks++; if (underflow_cnt !== 16'd3) begin n_fail++; $display("FAIL idle_ucnt got %0d exp 3", underflow_cnt); end
    n_checks++; if (data_out !== 14'h2000) begin n_fail++; $display("FAIL idle_data got %h exp 2000", data_out); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid got %b exp 0", out_valid); end
  endtask

  task automatic test_single_source();
    do_reset();
    tick(); tick();
    req_valid = 4'b0010; req_data[14 +: 14] = 14'h1ABC;
    #1;
    n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL single_ready got %b exp 0010", req_ready); end
    tick();
    req_valid = '0;
    n_checks++; if (fifo_level !== 3'd1) begin n_fail++; $display("FAIL single_level got %0d exp 1", fifo_level); end
    repeat (5) tick();
    n_checks++; if (frame_start !== 1'b1) begin n_fail++; $display("FAIL single_fs got %b exp 1", frame_start); end
    n_checks++; if (data_out !== 14'h1ABC) begin n_fail++; $display("FAIL single_data got %h exp 1abc", data_out); end
    n_checks++; if (ch_out !== 2'd1) begin n_fail++; $display("FAIL single_ch got %0d exp 1", ch_out); end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b exp 1", out_valid); end
    n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL single_level2 got %0d exp 0", fifo_level); end
    repeat (8) tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_uf_valid got %b exp 0", out_valid); end
    n_checks++; if (data_out !== 14'h2000) begin n_fail++; $display("FAIL single_uf_data got %h exp 2000", data_out); end
    n_checks++; if (ch_out !== 2'd1) begin n_fail++; $display("FAIL single_uf_ch got %0d exp 1", ch_out); end
    n_checks++; if (underflow_cnt !== 16'd1) begin n_fail++; $display("FAIL single_uf_ucnt got %0d exp 1", underflow_cnt); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_rdy;
    do_reset();
    req_valid = 4'hF; req_data = RR_DATA;
    #1;
    for (int c = 0; c < 4; c++) begin
      exp_rdy = 4'b0001 << c;
      n_checks++;
      if (req_ready !== exp_rdy) begin n_fail++; $display("FAIL rr_grant cycle %0d got %b exp %b", c, req_ready, exp_rdy); end
      tick();
    end
    n_checks++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL rr_full_level got %0d exp 4", fifo_level); end
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL rr_full_ready got %b exp 0000", req_ready); end
    repeat (3) tick();
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL rr_pop_cycle_ready got %b exp 0000", req_ready); end
    tick();
    n_checks++; if (data_out !== 14'h0100) begin n_fail++; $display("FAIL rr_pop1_data got %h exp 0100", data_out); end
    n_checks++; if (ch_out !== 2'd0) begin n_fail++; $display("FAIL rr_pop1_ch got %0d exp 0", ch_out); end
    n_checks++; if (fifo_level !== 3'd3) begin n_fail++; $display("FAIL rr_pop1_level got %0d exp 3", fifo_level); end
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rr_regrant0 got %b exp 0001", req_ready); end
    tick();
    n_checks++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL rr_refill_level got %0d exp 4", fifo_level); end
    repeat (7) tick();
    n_checks++; if (ch_out !== 2'd1) begin n_fail++; $display("FAIL rr_pop2_ch got %0d exp 1", ch_out); end
    n_checks++; if (data_out !== 14'h0200) begin n_fail++; $display("FAIL rr_pop2_data got %h exp 0200", data_out); end
    n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL rr_regrant1 got %b exp 0010", req_ready); end
    req_valid = '0;
  endtask

  task automatic test_hold_last();
    do_reset();
    hold_last = 1'b1;
    req_valid = 4'b0100; req_data[28 +: 14] = 14'h3FFF;
    #1;
    n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL hold_ready got %b exp 0100", req_ready); end
    tick();
    req_valid = '0;
    repeat (7) tick();
    n_checks++; if (data_out !== 14'h3FFF || out_valid !== 1'b1) begin n_fail++; $display("FAIL hold_load got %h/%b exp 3fff/1", data_out, out_valid); end
    repeat (8) tick();
    n_checks++; if (data_out !== 14'h3FFF || out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_uf1 got %h/%b exp 3fff/0", data_out, out_valid); end
    n_checks++; if (underflow_cnt !== 16'd1) begin n_fail++; $display("FAIL hold_ucnt1 got %0d exp 1", underflow_cnt); end
    repeat (8) tick();
    n_checks++; if (data_out !== 14'h3FFF || ch_out !== 2'd2) begin n_fail++; $display("FAIL hold_uf2 got %h/%0d exp 3fff/2", data_out, ch_out); end
    n_checks++; if (underflow_cnt !== 16'd2) begin n_fail++; $display("FAIL hold_ucnt2 got %0d exp 2", underflow_cnt); end
    hold_last = 1'b0;
    repeat (4) tick();
    n_checks++; if (data_out !== 14'h3FFF) begin n_fail++; $display("FAIL hold_midframe got %h exp 3fff", data_out); end
    repeat (4) tick();
    n_checks++; if (data_out !== 14'h2000) begin n_fail++; $display("FAIL hold_release got %h exp 2000", data_out); end
    n_checks++; if (underflow_cnt !== 16'd3) begin n_fail++; $display("FAIL hold_ucnt3 got %0d exp 3", underflow_cnt); end
  endtask

  task automatic test_enable_pause();
    do_reset();
    req_valid = 4'b1000; req_data[42 +: 14] = 14'h0123;
    #1;
    n_checks++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL pause_ready got %b exp 1000", req_ready); end
    tick();
    req_valid = '0;
    repeat (7) tick();
    n_checks++; if (data_out !== 14'h0123 || ch_out !== 2'd3) begin n_fail++; $display("FAIL pause_load got %h/%0d exp 0123/3", data_out, ch_out); end
    repeat (5) tick();
    enable = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      n_checks++;
      if (frame_start !== 1'b0 || data_out !== 14'h0123 || out_valid !== 1'b1) begin
        n_fail++; $display("FAIL pause_frozen step %0d got fs=%b data=%h v=%b exp 0/0123/1", i, frame_start, data_out, out_valid);
      end
    end
    n_checks++; if (underflow_cnt !== 16'd0) begin n_fail++; $display("FAIL pause_ucnt got %0d exp 0", underflow_cnt); end
    enable = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      n_checks++;
      if (frame_start !== (i == 8)) begin n_fail++; $display("FAIL resume_fs step %0d got %b exp %b", i, frame_start, i == 8); end
    end
    n_checks++; if (out_valid !== 1'b0 || underflow_cnt !== 16'd1) begin n_fail++; $display("FAIL resume_uf got %b/%0d exp 0/1", out_valid, underflow_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    repeat (8) tick();
    n_checks++; if (underflow_cnt !== 16'd1) begin n_fail++; $display("FAIL midrst_pre_ucnt got %0d exp 1", underflow_cnt); end
    req_valid = 4'hF; req_data = RR_DATA;
    repeat (4) tick();
    req_valid = '0;
    repeat (4) tick();
    n_checks++; if (fifo_level !== 3'd3 || out_valid !== 1'b1 || data_out !== 14'h0100) begin
      n_fail++; $display("FAIL midrst_pre_state got lvl=%0d v=%b data=%h exp 3/1/0100", fifo_level, out_valid, data_out);
    end
    repeat (2) tick();
    reset = 1'b1;
    tick();
    n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL midrst_level got %0d exp 0", fifo_level); end
    n_checks++; if (data_out !== 14'h2000) begin n_fail++; $display("FAIL midrst_data got %h exp 2000", data_out); end
    n_checks++; if (underflow_cnt !== 16'd0) begin n_fail++; $display("FAIL midrst_ucnt got %0d exp 0", underflow_cnt); end
    n_checks++; if (out_valid !== 1'b0 || ch_out !== 2'd0) begin n_fail++; $display("FAIL midrst_out got %b/%0d exp 0/0", out_valid, ch_out); end
    reset = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      n_checks++;
      if (frame_start !== (i == 8)) begin n_fail++; $display("FAIL midrst_fs step %0d got %b exp %b", i, frame_start, i == 8); end
    end
    n_checks++; if (out_valid !== 1'b0 || underflow_cnt !== 16'd1) begin n_fail++; $display("FAIL midrst_first_frame got %b/%0d exp 0/1", out_valid, underflow_cnt); end
  endtask

  initial begin
    test_reset();
    test_idle_underflow();
    test_single_source();
    test_round_robin();
    test_hold_last();
    test_enable_pause();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
